// File: rtl/uuid_hit_counter_pkg.sv
// Shared types and helpers for the UUID hit counter.
package uuid_hit_counter_pkg;

    // Operation carried through the read-modify-write pipeline.
    typedef enum logic [1:0] {
        OP_NONE     = 2'd0,
        OP_INC      = 2'd1,
        OP_READ     = 2'd2,
        OP_READ_CLR = 2'd3
    } op_t;

    // Table controller state.
    typedef enum logic {
        ST_CLR = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    // Widest counter the saturating helper supports.
    localparam int SAT_MAX_W = 64;

    // Saturating increment of the low `width` bits of `value`; bits above width are returned as zero.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                     input int                   width);
        logic [SAT_MAX_W-1:0] mask;
        if (width >= SAT_MAX_W) begin
            mask = '1;
        end else begin
            mask = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
        end
        if ((value & mask) == mask) begin
            return mask;
        end
        return (value + SAT_MAX_W'(1)) & mask;
    endfunction

endpackage

// File: rtl/uuid_hit_counter_if.sv
// Hashed-ID stream and stats request/response bundle for the hit counter.
interface uuid_hit_counter_if #(
    parameter int CRC_WIDTH = 8,
    parameter int CNT_WIDTH = 32
);
    logic [CRC_WIDTH-1:0] uuid_axis_tdata;
    logic                 uuid_axis_tvalid;
    logic                 uuid_axis_tready;

    logic [CRC_WIDTH-1:0] stat_req_addr;
    logic                 stat_req_clear;
    logic                 stat_req_valid;
    logic                 stat_req_ready;

    logic [CNT_WIDTH-1:0] stat_resp_data;
    logic                 stat_resp_valid;

    // Upstream hash stage and stats client side.
    modport master (
        output uuid_axis_tdata,
        output uuid_axis_tvalid,
        input  uuid_axis_tready,
        output stat_req_addr,
        output stat_req_clear,
        output stat_req_valid,
        input  stat_req_ready,
        input  stat_resp_data,
        input  stat_resp_valid
    );

    // Counter block side.
    modport slave (
        input  uuid_axis_tdata,
        input  uuid_axis_tvalid,
        output uuid_axis_tready,
        input  stat_req_addr,
        input  stat_req_clear,
        input  stat_req_valid,
        output stat_req_ready,
        output stat_resp_data,
        output stat_resp_valid
    );
endinterface

// File: rtl/simple_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old contents.
module simple_dp_ram #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 256,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data
);
    logic [DWIDTH-1:0] mem [DEPTH];

    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/uuid_hit_counter.sv
// Per-UUID saturating hit counters with a stats read/clear port and a table sweep.
//
// state  | meaning
// ST_CLR | sweeping zeros through the table, one entry per cycle; busy=1, no ops accepted
// ST_RUN | normal operation: UUID increments and stats requests accepted
module uuid_hit_counter
    import uuid_hit_counter_pkg::*;
#(
    parameter int CRC_WIDTH = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    uuid_hit_counter_if.slave   bus,
    input  logic                clear_all,
    output logic                busy
);
    localparam int DEPTH = 2 ** CRC_WIDTH;

    typedef logic [CRC_WIDTH-1:0] addr_t;
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam addr_t ADDR_LAST = '1;

    state_t state_q, state_d;
    addr_t  sweep_addr_q, sweep_addr_d;

    op_t    s1_op_q, s1_op_d;
    addr_t  s1_addr_q, s1_addr_d;

    logic   fwd_valid_q, fwd_valid_d;
    addr_t  fwd_addr_q, fwd_addr_d;
    cnt_t   fwd_data_q, fwd_data_d;

    logic   resp_valid_q, resp_valid_d;
    cnt_t   resp_data_q, resp_data_d;

    logic   run;
    logic   sweep_we;
    logic   stat_ready;
    logic   uuid_ready;
    logic   stat_fire;
    logic   uuid_fire;

    addr_t  rd_addr;
    cnt_t   rd_data;
    logic   fwd_hit;
    cnt_t   old_val;
    logic   s1_we;
    cnt_t   s1_wr_data;

    logic   ram_we;
    addr_t  ram_wr_addr;
    cnt_t   ram_wr_data;

    // State register for the sweep FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_CLR;
            sweep_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            sweep_addr_q <= sweep_addr_d;
        end
    end

    // Next state: walk the sweep address to the last entry, restart on clear_all.
    always_comb begin
        state_d      = state_q;
        sweep_addr_d = sweep_addr_q;
        case (state_q)
            ST_CLR: begin
                if (clear_all) begin
                    sweep_addr_d = '0;
                end else begin
                    sweep_addr_d = sweep_addr_q + addr_t'(1);
                    if (sweep_addr_q == ADDR_LAST) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (clear_all) begin
                    state_d      = ST_CLR;
                    sweep_addr_d = '0;
                end
            end
            default: begin
                state_d      = ST_CLR;
                sweep_addr_d = '0;
            end
        endcase
    end

    // FSM outputs: busy, sweep write enable and the stats-first ready arbitration.
    always_comb begin
        run        = (state_q == ST_RUN);
        busy       = !run;
        sweep_we   = (state_q == ST_CLR);
        stat_ready = run && !clear_all;
        uuid_ready = run && !clear_all && !bus.stat_req_valid;
    end

    assign bus.stat_req_ready   = stat_ready;
    assign bus.uuid_axis_tready = uuid_ready;

    // Stage 0: pick the accepted op and issue its RAM read.
    always_comb begin
        stat_fire = bus.stat_req_valid && stat_ready;
        uuid_fire = bus.uuid_axis_tvalid && uuid_ready;
        rd_addr   = stat_fire ? bus.stat_req_addr : bus.uuid_axis_tdata;
        s1_addr_d = rd_addr;
        s1_op_d   = OP_NONE;
        if (stat_fire) begin
            s1_op_d = bus.stat_req_clear ? OP_READ_CLR : OP_READ;
        end else if (uuid_fire) begin
            s1_op_d = OP_INC;
        end
    end

    // Stage 1: resolve the old value (forwarded or from RAM) and compute the write-back.
    always_comb begin
        fwd_hit    = fwd_valid_q && (fwd_addr_q == s1_addr_q);
        old_val    = fwd_hit ? fwd_data_q : rd_data;
        s1_we      = 1'b0;
        s1_wr_data = '0;
        case (s1_op_q)
            OP_INC: begin
                s1_we      = 1'b1;
                s1_wr_data = cnt_t'(sat_inc(SAT_MAX_W'(old_val), CNT_WIDTH));
            end
            OP_READ_CLR: begin
                s1_we      = 1'b1;
                s1_wr_data = '0;
            end
            default: begin
                s1_we      = 1'b0;
                s1_wr_data = '0;
            end
        endcase
    end

    // Forwarding register tracks the last write; a table clear invalidates it.
    always_comb begin
        fwd_valid_d = fwd_valid_q;
        fwd_addr_d  = fwd_addr_q;
        fwd_data_d  = fwd_data_q;
        if (s1_we) begin
            fwd_valid_d = 1'b1;
            fwd_addr_d  = s1_addr_q;
            fwd_data_d  = s1_wr_data;
        end
        if (run && clear_all) begin
            fwd_valid_d = 1'b0;
        end
    end

    // Response: reads report the pre-clear value two cycles after acceptance.
    always_comb begin
        resp_valid_d = (s1_op_q == OP_READ) || (s1_op_q == OP_READ_CLR);
        resp_data_d  = resp_valid_d ? old_val : resp_data_q;
    end

    // Sweep and stage-1 writes share the write port; they are never active together.
    always_comb begin
        ram_we      = sweep_we || s1_we;
        ram_wr_addr = sweep_we ? sweep_addr_q : s1_addr_q;
        ram_wr_data = sweep_we ? cnt_t'(0) : s1_wr_data;
    end

    // Pipeline, forwarding and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_op_q      <= OP_NONE;
            s1_addr_q    <= '0;
            fwd_valid_q  <= 1'b0;
            fwd_addr_q   <= '0;
            fwd_data_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            s1_op_q      <= s1_op_d;
            s1_addr_q    <= s1_addr_d;
            fwd_valid_q  <= fwd_valid_d;
            fwd_addr_q   <= fwd_addr_d;
            fwd_data_q   <= fwd_data_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign bus.stat_resp_valid = resp_valid_q;
    assign bus.stat_resp_data  = resp_data_q;

    simple_dp_ram #(
        .DWIDTH (CNT_WIDTH),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .rd_en   (1'b1),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_uuid_hit_counter.sv
// Self-checking bench for uuid_hit_counter with a response scoreboard.
module tb_uuid_hit_counter;
    localparam int CRC_W = 4;
    localparam int CNT_W = 4;
    localparam int N     = 2 ** CRC_W;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic clear_all;
    logic busy;

    uuid_hit_counter_if #(.CRC_WIDTH(CRC_W), .CNT_WIDTH(CNT_W)) bus ();

    uuid_hit_counter #(
        .CRC_WIDTH (CRC_W),
        .CNT_WIDTH (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .clear_all (clear_all),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int cyc;
        int addr;
        int data;
    } resp_t;

    resp_t sb_q[$];
    int    model[N];
    int    cyc = 0;

    // Reference model and scoreboard, sampled away from the active edge.
    always @(negedge clk) begin
        resp_t e;
        int    a;
        cyc++;
        if (rst) begin
            sb_q.delete();
            for (int i = 0; i < N; i++) model[i] = 0;
        end else begin
            if (bus.stat_resp_valid) begin
                if (sb_q.size() == 0) begin
                    chk("resp_unexpected", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("resp_data[%0d]", e.addr), bus.stat_resp_data, e.data);
                    chk("resp_latency", cyc - e.cyc, 2);
                end
            end
            if (clear_all) begin
                for (int i = 0; i < N; i++) model[i] = 0;
            end else if (bus.stat_req_valid && bus.stat_req_ready) begin
                a = int'(bus.stat_req_addr);
                e.cyc  = cyc;
                e.addr = a;
                e.data = model[a];
                sb_q.push_back(e);
                if (bus.stat_req_clear) model[a] = 0;
            end else if (bus.uuid_axis_tvalid && bus.uuid_axis_tready) begin
                a = int'(bus.uuid_axis_tdata);
                if (model[a] < CMAX) model[a] = model[a] + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic inc(input int a);
        bus.uuid_axis_tdata  = CRC_W'(a);
        bus.uuid_axis_tvalid = 1'b1;
        step();
        bus.uuid_axis_tvalid = 1'b0;
    endtask

    task automatic stat(input int a, input bit clr);
        bus.stat_req_addr  = CRC_W'(a);
        bus.stat_req_clear = clr;
        bus.stat_req_valid = 1'b1;
        step();
        bus.stat_req_valid = 1'b0;
        bus.stat_req_clear = 1'b0;
    endtask

    task automatic measure_busy(input string tag, input int exp);
        int n = 0;
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (busy) n++;
            else done = 1;
        end
        chk(tag, n, exp);
        step();
    endtask

    initial begin
        rst                  = 1'b1;
        clear_all            = 1'b0;
        bus.uuid_axis_tdata  = '0;
        bus.uuid_axis_tvalid = 1'b0;
        bus.stat_req_addr    = '0;
        bus.stat_req_clear   = 1'b0;
        bus.stat_req_valid   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_resp_valid", bus.stat_resp_valid, 0);
        chk("rst_resp_data", bus.stat_resp_data, 0);
        chk("rst_stat_ready", bus.stat_req_ready, 0);
        chk("rst_tready", bus.uuid_axis_tready, 0);
        step();
        rst = 1'b0;
        measure_busy("busy_after_reset", N);

        for (int a = 0; a < N; a++) stat(a, 1'b0);
        idle(3);

        for (int i = 0; i < 10; i++) inc(5);
        stat(5, 1'b0);
        idle(3);

        inc(3); inc(7); inc(3); inc(7); inc(3);
        stat(3, 1'b1);
        stat(3, 1'b0);
        idle(3);

        inc(8); inc(8);
        stat(8, 1'b1);
        inc(8);
        stat(8, 1'b0);
        idle(3);

        for (int i = 0; i < 20; i++) inc(1);
        stat(1, 1'b0);
        idle(3);

        bus.stat_req_addr    = CRC_W'(6);
        bus.stat_req_clear   = 1'b0;
        bus.stat_req_valid   = 1'b1;
        bus.uuid_axis_tdata  = CRC_W'(6);
        bus.uuid_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("tready_blocked", bus.uuid_axis_tready, 0);
            step();
        end
        bus.stat_req_valid = 1'b0;
        @(negedge clk);
        chk("tready_released", bus.uuid_axis_tready, 1);
        step();
        bus.uuid_axis_tvalid = 1'b0;
        idle(2);
        stat(6, 1'b0);
        idle(3);

        for (int i = 0; i < 4; i++) inc(2);
        stat(2, 1'b0);
        clear_all            = 1'b1;
        bus.uuid_axis_tdata  = CRC_W'(2);
        bus.uuid_axis_tvalid = 1'b1;
        @(negedge clk);
        chk("clear_stat_ready", bus.stat_req_ready, 0);
        chk("clear_tready", bus.uuid_axis_tready, 0);
        step();
        clear_all            = 1'b0;
        bus.uuid_axis_tvalid = 1'b0;
        measure_busy("busy_after_clear", N);
        stat(2, 1'b0);
        idle(3);

        inc(15); inc(15);
        clear_all = 1'b1;
        step();
        clear_all = 1'b0;
        idle(8);
        clear_all = 1'b1;
        step();
        clear_all = 1'b0;
        measure_busy("busy_clear_restart", N);

        inc(15); inc(14);
        clear_all = 1'b1;
        step();
        clear_all = 1'b0;
        idle(5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        measure_busy("busy_rst_restart", N);

        for (int a = 0; a < N; a++) stat(a, 1'b0);
        idle(4);
        chk("sb_drain", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
